// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//
// Purpose:
//   Up/down modulo counter with a synchronous load. The count runs over
//   0..MODULUS-1 and either wraps or saturates at the bounds (SATURATE).
//   Stepping past a bound is a "boundary event". A boundary event produces
//   a one-cycle registered pulse on 'wrap'. A load never counts as a
//   boundary event.
//
// Parameters:
//   NUM_BITS  - width of the count register
//   MODULUS   - count range 0..MODULUS-1, legal range 2..2**NUM_BITS
//   SATURATE  - 0 = wrap at the bounds, 1 = hold at the bounds
//
// Optional feature (macro MOD_COUNTER_OVF_STICKY_EN):
//   Adds a sticky overflow flag 'ovf' and its clear input 'clr_ovf'.
//   'ovf' sets after any boundary event and holds until clr_ovf or rst.
//   A set wins over a clear in the same cycle.
//
// Ports:
//   clk        in   1         sole clock, rising edge
//   rst        in   1         synchronous active-high reset
//   enable     in   1         count step request for this cycle
//   up         in   1         1 = increment, 0 = decrement
//   load       in   1         synchronous load strobe (beats enable)
//   load_value in   NUM_BITS  value to load, clamped to MODULUS-1
//   count      out  NUM_BITS  registered count
//   at_max     out  1         combinational, count == MODULUS-1
//   at_min     out  1         combinational, count == 0
//   wrap       out  1         registered boundary-event pulse
//   ovf        out  1         sticky overflow (macro builds only)
//   clr_ovf    in   1         clears ovf (macro builds only)
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int NUM_BITS = 8,
    parameter int MODULUS  = 2 ** NUM_BITS,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                up,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_value,
    output logic [NUM_BITS-1:0] count,
    output logic                at_max,
    output logic                at_min,
    output logic                wrap
`ifdef MOD_COUNTER_OVF_STICKY_EN
   ,output logic                ovf,
    input  logic                clr_ovf
`endif
);

    // The modulus is held one bit wider than the count so that
    // MODULUS == 2**NUM_BITS fits when comparing against load_value.
    localparam logic [NUM_BITS-1:0] MAX_VAL = NUM_BITS'(MODULUS - 1);
    localparam logic [NUM_BITS:0]   MOD_EXT = (NUM_BITS + 1)'(MODULUS);
    localparam logic [NUM_BITS-1:0] ONE     = NUM_BITS'(1);

    logic [NUM_BITS-1:0] r_count;
    logic                r_wrap;
    logic [NUM_BITS-1:0] w_countNext;
    logic                w_boundary;

    // Next-count selection. Load beats enable. The step never leaves
    // 0..MODULUS-1 because the bounds are tested before the add or
    // subtract. This also keeps the all-ones case free of width overflow.
    always_comb begin
        w_countNext = r_count;
        w_boundary  = 1'b0;
        if (load) begin
            if ({1'b0, load_value} < MOD_EXT) begin
                w_countNext = load_value;
            end else begin
                w_countNext = MAX_VAL;
            end
        end else if (enable) begin
            if (up) begin
                if (r_count == MAX_VAL) begin
                    w_boundary  = 1'b1;
                    w_countNext = (SATURATE != 0) ? r_count : '0;
                end else begin
                    w_countNext = r_count + ONE;
                end
            end else begin
                if (r_count == '0) begin
                    w_boundary  = 1'b1;
                    w_countNext = (SATURATE != 0) ? r_count : MAX_VAL;
                end else begin
                    w_countNext = r_count - ONE;
                end
            end
        end
    end

    // Count and wrap registers. The wrap output is simply the registered
    // boundary flag. It drops on any cycle without a boundary event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_wrap  <= w_boundary;
        end
    end

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic r_ovf;

    // Sticky overflow. The boundary check comes first, so a coincident
    // clear loses and the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_boundary) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign count  = r_count;
    assign wrap   = r_wrap;
    assign at_max = (r_count == MAX_VAL);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
//
// Three counters share the same stimulus each cycle:
//   A: MODULUS=10,  wrapping
//   B: MODULUS=10,  saturating
//   C: MODULUS=256, wrapping (full-width modulus)
// The stimulus side runs an integer reference model. It pushes the
// expected post-edge state into a queue. A separate monitor pops one
// entry after every rising edge and compares it with all three DUTs.
// ---------------------------------------------------------------------------
module tb_mod_counter;

    typedef struct packed {
        logic [2:0][7:0] cnt;
        logic [2:0]      wrp;
        logic [2:0]      ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       clrOvf = 1'b0;
    logic [7:0] loadValue = '0;

    logic [7:0] countA, countB, countC;
    logic       atMaxA, atMaxB, atMaxC;
    logic       atMinA, atMinB, atMinC;
    logic       wrapA, wrapB, wrapC;
`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic       ovfA, ovfB, ovfC;
`endif

    mod_counter #(.NUM_BITS(8), .MODULUS(10), .SATURATE(0)) dutA (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .count(countA), .at_max(atMaxA),
        .at_min(atMinA), .wrap(wrapA)
`ifdef MOD_COUNTER_OVF_STICKY_EN
       ,.ovf(ovfA), .clr_ovf(clrOvf)
`endif
    );

    mod_counter #(.NUM_BITS(8), .MODULUS(10), .SATURATE(1)) dutB (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .count(countB), .at_max(atMaxB),
        .at_min(atMinB), .wrap(wrapB)
`ifdef MOD_COUNTER_OVF_STICKY_EN
       ,.ovf(ovfB), .clr_ovf(clrOvf)
`endif
    );

    mod_counter #(.NUM_BITS(8)) dutC (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .count(countC), .at_max(atMaxC),
        .at_min(atMinC), .wrap(wrapC)
`ifdef MOD_COUNTER_OVF_STICKY_EN
       ,.ovf(ovfC), .clr_ovf(clrOvf)
`endif
    );

    // Reference model state, one slot per DUT
    int   mMod[3] = '{10, 10, 256};
    bit   mSat[3] = '{1'b0, 1'b1, 1'b0};
    int   mCnt[3] = '{0, 0, 0};
    bit   mOvf[3] = '{1'b0, 1'b0, 1'b0};
    exp_t expQ[$];

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expectation
    task automatic applyStimulus(input bit iRst, input bit iEn, input bit iUp,
                                 input bit iLoad, input int iLv, input bit iClr);
        exp_t e;
        @(negedge clk);
        rst       = iRst;
        enable    = iEn;
        up        = iUp;
        load      = iLoad;
        loadValue = 8'(iLv);
        clrOvf    = iClr;
        for (int k = 0; k < 3; k++) begin
            bit boundary;
            int nxt;
            boundary = 1'b0;
            if (iRst) begin
                mCnt[k] = 0;
                mOvf[k] = 1'b0;
            end else begin
                if (iLoad) begin
                    mCnt[k] = (iLv < mMod[k]) ? iLv : mMod[k] - 1;
                end else if (iEn) begin
                    nxt = iUp ? mCnt[k] + 1 : mCnt[k] - 1;
                    if (nxt >= mMod[k] || nxt < 0) begin
                        boundary = 1'b1;
                        if (!mSat[k]) mCnt[k] = iUp ? 0 : mMod[k] - 1;
                    end else begin
                        mCnt[k] = nxt;
                    end
                end
                if (boundary) mOvf[k] = 1'b1;
                else if (iClr) mOvf[k] = 1'b0;
            end
            e.cnt[k] = 8'(mCnt[k]);
            e.wrp[k] = boundary;
            e.ovf[k] = mOvf[k];
        end
        expQ.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, compared 1 ns after it
    initial begin
        exp_t e;
        logic [2:0][7:0] aCnt;
        logic [2:0] aWrap, aMax, aMin;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e     = expQ.pop_front();
                aCnt  = {countC, countB, countA};
                aWrap = {wrapC, wrapB, wrapA};
                aMax  = {atMaxC, atMaxB, atMaxA};
                aMin  = {atMinC, atMinB, atMinA};
                for (int k = 0; k < 3; k++) begin
                    checkOutput($sformatf("count[%0d]", k), int'(aCnt[k]), int'(e.cnt[k]));
                    checkOutput($sformatf("wrap[%0d]", k), int'(aWrap[k]), int'(e.wrp[k]));
                    checkOutput($sformatf("at_max[%0d]", k), int'(aMax[k]),
                                (int'(e.cnt[k]) == mMod[k] - 1) ? 1 : 0);
                    checkOutput($sformatf("at_min[%0d]", k), int'(aMin[k]),
                                (e.cnt[k] == 8'd0) ? 1 : 0);
                end
`ifdef MOD_COUNTER_OVF_STICKY_EN
                checkOutput("ovf[0]", int'(ovfA), int'(e.ovf[0]));
                checkOutput("ovf[1]", int'(ovfB), int'(e.ovf[1]));
                checkOutput("ovf[2]", int'(ovfC), int'(e.ovf[2]));
`endif
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with enable/up asserted, then the first count
        repeat (10) applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);

        // Clean reset, then 12 up steps through the 9->0 wrap
        applyStimulus(1, 0, 1, 0, 0, 0);
        repeat (12) applyStimulus(0, 1, 1, 0, 0, 0);

        // Down from 0: wrap to 9 on A, saturate with pulses on B, 255 on C
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);

        // Load at bound with enable, then load clamping
        applyStimulus(0, 0, 1, 1, 9, 0);
        applyStimulus(0, 1, 1, 1, 7, 0);
        applyStimulus(0, 1, 1, 1, 200, 0);
        applyStimulus(0, 1, 1, 1, 255, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);

        // Pause at 4 for 10 cycles, then resume
        applyStimulus(0, 0, 1, 1, 4, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1'(i), 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);

        // Sticky flag: clear, set via wrap, clear coincident with a boundary
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 9, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 9, 0);
        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);

        // Reset mid-count, then resume from 0
        applyStimulus(0, 1, 1, 1, 5, 0);
        applyStimulus(1, 1, 1, 1, 3, 1);
        applyStimulus(0, 1, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          int'($urandom_range(0, 255)),
                          ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, meaning count register width.
REQ-002 SHALL have parameter MODULUS, default 2**NUM_BITS, meaning count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**NUM_BITS.
REQ-003 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at bounds and 1 = hold at bounds.
REQ-004 SHALL have port clk  in  1  sole clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  in  1  count step request for this cycle.
REQ-007 SHALL have port up  in  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  in  1  synchronous load strobe.
REQ-009 SHALL have port load_value  in  NUM_BITS  value to load.
REQ-010 SHALL have port count  out  NUM_BITS  registered count.
REQ-011 SHALL have port at_max  out  1  combinational, high iff count == MODULUS-1.
REQ-012 SHALL have port at_min  out  1  combinational, high iff count == 0.
REQ-013 SHALL have port wrap  out  1  registered one-cycle boundary-event pulse.
REQ-014 SHALL have ports ovf  out  1 and clr_ovf  in  1 only when MOD_COUNTER_OVF_STICKY_EN is defined.

Function
REQ-015 SHALL apply update priority, highest first: rst, then load, then enable; with none active, count holds.
REQ-016 SHALL on load set count to load_value if load_value < MODULUS, else to MODULUS-1.
REQ-017 SHALL on enable with up=1 set count to count+1 when count < MODULUS-1.
REQ-018 SHALL on enable with up=0 set count to count-1 when count > 0.
REQ-019 SHALL treat enable with up=1 at count == MODULUS-1, or with up=0 at count == 0, as a boundary event.
REQ-020 SHALL on a boundary event set count to 0 (up) or MODULUS-1 (down) when SATURATE=0, and hold count when SATURATE=1.
REQ-021 SHALL drive wrap high for exactly the cycle after each boundary event and low otherwise; consecutive boundary events give consecutive high cycles.
REQ-022 SHALL NOT raise wrap when load takes effect, including load asserted together with enable at a bound.
REQ-023 SHALL perform all arithmetic without width overflow, including MODULUS == 2**NUM_BITS (wrap from all-ones to 0 and back).
REQ-024 SHALL hold count and force wrap to 0 on cycles where enable=0 and load=0.

Reset
REQ-025 SHALL on rst set count=0, wrap=0 and ovf=0 at the next rising edge, overriding load, enable and clr_ovf.
REQ-026 SHALL allow reset mid-count, with counting resuming from 0 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile the sticky overflow feature only when the macro MOD_COUNTER_OVF_STICKY_EN is defined.
REQ-028 SHALL when the macro is defined set ovf in the cycle after any boundary event and hold it until clr_ovf or rst; a set and clr_ovf in the same cycle leaves ovf=1.
REQ-029 SHALL when the macro is not defined omit ovf, clr_ovf and their register, with all other behaviour unchanged.

Verification
REQ-030 SHALL cover reset: rst=1 for 10 cycles with enable=1, up=1 -> count=0, wrap=0 throughout; rst=0 -> count 1 after the first enabled edge.
REQ-031 SHALL cover up-wrap: NUM_BITS=8, MODULUS=10, SATURATE=0, 12 enabled up cycles from 0 -> count 1..9,0,1,2; wrap=1 only in the cycle after 9->0; at_max=1 while count=9.
REQ-032 SHALL cover down and saturate: from 0 with up=0, SATURATE=0 -> count 9 and wrap pulse; with SATURATE=1 -> count stays 0, wrap pulses each enabled cycle.
REQ-033 SHALL cover load: load=1, load_value=7, enable=1 at count=9 -> count=7, wrap=0; load_value=200 with MODULUS=10 -> count=9.
REQ-034 SHALL cover pause: enable low 10 cycles at count=4 -> count stays 4, wrap=0; re-enable -> 5.
REQ-035 SHALL cover the sticky flag with the macro defined: a wrap sets ovf=1, which persists; clr_ovf -> ovf=0; clr_ovf coincident with a boundary event -> ovf=1.
